// File: rtl/sram_pkg.sv
// Shared helpers for the SRAM behavioural models.
// Merge rule and limits common to every variant.
package sram_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int MAX_WIDTH        = 1024;

    typedef logic [MAX_WIDTH-1:0] sram_word_t;

    // Mask bit 1 keeps the stored bit, 0 takes the new data bit.
    function automatic sram_word_t masked_merge(
        input sram_word_t old,
        input sram_word_t d,
        input sram_word_t m
    );
        return (d & ~m) | (old & m);
    endfunction

endpackage

// File: rtl/double_port_sram_pipelined_if.sv
// Write/read port bundle of the pipelined two-port SRAM.
// Master drives requests, slave returns Q/QV.
interface double_port_sram_pipelined_if #(
    parameter int WIDTH = 128,
    parameter int AW    = 12
);

    logic             REB;
    logic             WEB;
    logic [AW-1:0]    AA;
    logic [AW-1:0]    AB;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Q;
    logic             QV;

    modport master (
        output REB, WEB, AA, AB, D, M,
        input  Q, QV
    );

    modport slave (
        input  REB, WEB, AA, AB, D, M,
        output Q, QV
    );

endinterface

// File: rtl/sram_read_pipeline.sv
// Valid+data delay line behind the read stage.
// Output data only moves with a valid, so Q holds between reads.
module sram_read_pipeline #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused;
        assign unused    = &{1'b0, clk, rst};
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld;
        logic [WIDTH-1:0] dat [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    dat[i] <= '0;
                end
            end else begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= in_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        dat[i] <= dat[i-1];
                    end
                end
            end
        end

        assign out_valid = vld[DEPTH-1];
        assign out_data  = dat[DEPTH-1];
    end

endmodule

// File: rtl/double_port_sram_pipelined.sv
// Two-port SRAM model: masked write port, read port with
// configurable output latency and optional write forwarding.
module double_port_sram_pipelined
    import sram_pkg::*;
#(
    parameter int WIDTH          = 128,
    parameter int NUM_ROWS       = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int FORWARD_WRITES = 0
) (
    input  logic CLK,
    input  logic RST,
    double_port_sram_pipelined_if.slave bus
);

    localparam int AddressWidth = $clog2(NUM_ROWS);
    localparam logic [AddressWidth:0] Rows = NUM_ROWS[AddressWidth:0];

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
        $error("READ_LATENCY must be within 1..4");
    end
    if (NUM_ROWS < 2) begin : g_bad_rows
        $error("NUM_ROWS must be at least 2");
    end
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("WIDTH out of supported range");
    end

    logic [WIDTH-1:0] mem [NUM_ROWS];

    logic             wr_in;
    logic             rd_in;
    logic             wr_en;
    logic             collide;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_word;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;

    assign wr_in   = {1'b0, bus.AA} < Rows;
    assign rd_in   = {1'b0, bus.AB} < Rows;
    assign wr_en   = !bus.WEB && wr_in;
    assign collide = (FORWARD_WRITES != 0) && wr_en
                     && (bus.AA == bus.AB);

    assign wr_word = WIDTH'(masked_merge(
        sram_word_t'(mem[bus.AA]),
        sram_word_t'(bus.D),
        sram_word_t'(bus.M)));

    // Out-of-range reads return zero rather than whatever aliases.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = collide ? wr_word : mem[bus.AB];
        end
    end

    // Array is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[bus.AA] <= wr_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= !bus.REB;
            if (!bus.REB) begin
                s1_data <= rd_word;
            end
        end
    end

    sram_read_pipeline #(
        .WIDTH (WIDTH),
        .DEPTH (READ_LATENCY - 1)
    ) u_pipe (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .out_valid (q_valid),
        .out_data  (q_data)
    );

    assign bus.Q  = q_data;
    assign bus.QV = q_valid;

endmodule

// File: doc/double_port_sram_pipelined.md
Name: double_port_sram_pipelined

Overview:
Parametrised successor to the single-cycle two-port TSMC-style SRAM model: one write port, one read port, bit-masked writes. Adds configurable read latency (output pipeline), a read-valid strobe, selectable write-to-read forwarding on same-address collisions, asynchronous reset of the output path, and safe handling of non-power-of-two depths. Sits between neuron/synapse state controllers and the physical macro; it stands in for the macro in simulation and FPGA builds.

Parameters:
WIDTH, 128, data/mask width in bits
NUM_ROWS, 4096, number of words; need not be a power of two
READ_LATENCY, 1, cycles from read issue to Q/QV; legal range 1..4
FORWARD_WRITES, 0, 1 = same-cycle same-address read returns newly written (merged) data; 0 = returns old data
AddressWidth (localparam), $clog2(NUM_ROWS), address bus width

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset of the output pipeline
REB  input  1  read enable, active low
WEB  input  1  write enable, active low
AA  input  AddressWidth  write address
AB  input  AddressWidth  read address
D  input  WIDTH  write data
M  input  WIDTH  write mask; 0 = overwrite bit, 1 = keep stored bit
Q  output  WIDTH  read data
QV  output  1  one-cycle pulse marking new data on Q

Behaviour:
- Reset: while RST=1, Q=0, QV=0 and all pipeline valid bits are cleared immediately. Array contents are not reset. In-flight reads are dropped and never produce QV.
- Write: on an edge with WEB=0 and AA<NUM_ROWS, SRAM[AA] <= (D & ~M) | (SRAM[AA] & M). Writes with AA>=NUM_ROWS are ignored. Writes are accepted during RST=1; the array is not under reset.
- Read issue: on an edge with REB=0 and RST=0, the word at AB is sampled into pipeline stage 1. If AB>=NUM_ROWS, the sampled word is 0.
- Latency: a read issued at edge t drives Q and QV=1 after edge t+READ_LATENCY-1. With READ_LATENCY=1 this is the edge of issue, which matches the legacy timing.
- Q holds its last read value until the next valid read reaches the output; it does not return to 0. QV is high for exactly one cycle per issued read. Back-to-back reads give one result per cycle with no bubbles.
- Same-cycle collision (REB=0, WEB=0, AA==AB, in range):
  - FORWARD_WRITES=1: the read returns the merged write value.
  - FORWARD_WRITES=0: the read returns the pre-write contents.
- A write that lands after a read was issued never alters that in-flight read. Data is captured at issue.
- A simultaneous read and write to different addresses are fully independent.
- No other hazards exist. The block has no backpressure, so the consumer must accept Q when QV=1.

Decomposition:
- Package sram_pkg holds:
  - function masked_merge(old, d, m), returning (d & ~m) | (old & m), shared with the other SRAM models.
  - localparam MAX_READ_LATENCY = 4, used in parameter assertions.
- Sub-module sram_read_pipeline #(WIDTH, DEPTH) is a valid+data shift register with async active-high reset that clears valids and the output data register. The top block instantiates it with DEPTH=READ_LATENCY-1; DEPTH=0 is a pass-through of the stage-1 register.
- Elaboration assertions: READ_LATENCY in 1..4, NUM_ROWS>=2.

Test Plan:
- Latency sweep: for READ_LATENCY=1,2,4, write 0xA5A5… to row 7, then issue a read of row 7 at edge t -> QV=1 and Q=0xA5A5… after edge t+READ_LATENCY-1 only. QV=0 at all other edges.
- Masked write: row 3 holds all-ones; write D=0, M=0x00FF…00FF -> row 3 reads back as 0x00FF…00FF.
- Collision: row 5 holds 0x1111, then a same-cycle write of 0x2222 (M=0) with a read of row 5. With FORWARD_WRITES=0, Q=0x1111; with FORWARD_WRITES=1, Q=0x2222. A following read of row 5 returns 0x2222 in both cases.
- Reset mid-flight: READ_LATENCY=3, issue reads of rows 1 and 2, assert RST asynchronously one cycle later -> Q=0 and QV=0 immediately, no QV after RST deasserts, and rows 1 and 2 keep their contents on re-read.
- Non-power-of-two: NUM_ROWS=100, write 0xDEAD to address 120 and read address 120 -> Q=0 and QV=1. Rows 0..99 are unchanged by the write.
- Streaming: 16 back-to-back reads of rows 0..15 with interleaved writes to other rows -> 16 consecutive QV pulses with data in issue order.
